// File: rtl/conv3_pkg.sv
// Shared widths, FSM encoding and lane-mask helper for the conv3 requantize/pack block.
// Imported by the top; the word FIFO stays generic and does not depend on it.
package conv3_pkg;

  localparam int ACC_W      = 28;
  localparam int BIAS_W     = 16;
  localparam int Q_W        = 8;
  localparam int LANES      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int WORD_W     = LANES * Q_W + LANES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Keep mask for a partial word holding n lanes (lanes 0..n-1 valid).
  function automatic logic [LANES-1:0] keep_mask(input logic [1:0] n);
    case (n)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/conv3_word_fifo.sv
// Generic FIFO, registered count; read data is the head entry, visible the cycle after push.
// Push while full and pop while empty are ignored; head entry holds until popped.
module conv3_word_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       CLR_N,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & (count != CW'(DEPTH));
  assign do_pop  = pop & (count != '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/conv3_quant_pack.sv
// conv3 requantizer: bias add, rounding shift, relu, int8 saturate, pack 4 lanes per word; 3-cycle latency.
// in_ready drops at 3 queued words or while draining a flush; the output word holds while out_valid & !out_ready.
module conv3_quant_pack
  import conv3_pkg::*;
(
  input  logic                 CLK,
  input  logic                 CLR_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_W-1:0]     in_data,
  input  logic [BIAS_W-1:0]    bias,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*Q_W-1:0] out_data,
  output logic [LANES-1:0]     out_keep
);

  localparam int SUM_W = ACC_W + 1;
  localparam int RND_W = ACC_W + 2;
  localparam logic signed [RND_W-1:0] Q_MAX = RND_W'(127);
  localparam logic signed [RND_W-1:0] Q_MIN = RND_W'(-128);

  state_t                    state;
  state_t                    state_nxt;
  logic                      run_q;
  logic                      accept;
  logic                      full_push;
  logic                      drain_done;
  logic                      push;
  logic [2:0]                fifo_count;
  logic [WORD_W-1:0]         push_word;
  logic [WORD_W-1:0]         fifo_dout;

  logic                      s1_vld;
  logic signed [SUM_W-1:0]   s1_sum;
  logic [3:0]                s1_shift;
  logic                      s1_relu;
  logic                      s2_vld;
  logic [Q_W-1:0]            s2_byte;

  logic [RND_W-1:0]          rnd;
  logic signed [RND_W-1:0]   rnd_sum;
  logic signed [RND_W-1:0]   shifted;
  logic [Q_W-1:0]            q_byte;

  logic [1:0]                lane_idx;
  logic [LANES-2:0][Q_W-1:0] lanes;

  // Pipeline never stalls: with <=2 words queued, in-flight bytes cannot complete two more words.
  assign in_ready = run_q & (fifo_count <= 3'd2) & (state != ST_DRAIN);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      s1_vld   <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_sum   <= {in_data[ACC_W-1], in_data} + {{(SUM_W-BIAS_W){bias[BIAS_W-1]}}, bias};
        s1_shift <= (shift > 5'd15) ? 4'd15 : shift[3:0];
        s1_relu  <= relu_en;
      end
    end
  end

  always_comb begin
    rnd = '0;
    if (s1_shift != 4'd0) begin
      rnd[s1_shift - 4'd1] = 1'b1;
    end
    rnd_sum = {s1_sum[SUM_W-1], s1_sum} + rnd;
    shifted = rnd_sum >>> s1_shift;
    q_byte  = shifted[Q_W-1:0];
    if (s1_relu && shifted[RND_W-1]) begin
      q_byte = '0;
    end else if (shifted > Q_MAX) begin
      q_byte = 8'h7F;
    end else if (shifted < Q_MIN) begin
      q_byte = 8'h80;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      s2_vld  <= 1'b0;
      s2_byte <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_byte <= q_byte;
      end
    end
  end

  // Lane 3 never needs storage: it goes straight from stage 2 into the pushed word.
  assign full_push  = s2_vld & (lane_idx == 2'd3);
  assign drain_done = (state == ST_DRAIN) & ~s1_vld & ~s2_vld & (fifo_count <= 3'd3);
  assign push       = full_push | (drain_done & (lane_idx != 2'd0));
  assign push_word  = full_push ? {{LANES{1'b1}}, s2_byte, lanes}
                                : {keep_mask(lane_idx), {Q_W{1'b0}}, lanes};

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      lane_idx <= '0;
      lanes    <= '0;
    end else if (s2_vld) begin
      if (lane_idx == 2'd3) begin
        lane_idx <= '0;
        lanes    <= '0;
      end else begin
        lanes[lane_idx] <= s2_byte;
        lane_idx        <= lane_idx + 2'd1;
      end
    end else if (drain_done) begin
      lane_idx <= '0;
      lanes    <= '0;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = flush ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  conv3_word_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .push      (push),
    .push_data (push_word),
    .pop       (out_valid & out_ready),
    .out_valid (out_valid),
    .out_data  (fifo_dout),
    .count     (fifo_count)
  );

  assign out_keep = fifo_dout[WORD_W-1 -: LANES];
  assign out_data = fifo_dout[LANES*Q_W-1:0];

endmodule

// File: doc/conv3_quant_pack.md
CONV3_QUANT_PACK -- requirements
Module: conv3_quant_pack

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port CLR_N, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, accumulated sum present on in_data.
REQ-004 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-005 SHALL have port in_data, input, 28, signed accumulated conv3 filter sum.
REQ-006 SHALL have port bias, input, 16, signed bias, sampled with each accepted in_data.
REQ-007 SHALL have port shift, input, 5, requantize right-shift 0..15; values 16..31 treated as 15.
REQ-008 SHALL have port relu_en, input, 1, clamp negatives to 0, sampled with each accepted in_data.
REQ-009 SHALL have port flush, input, 1, single-cycle pulse, emit partial word.
REQ-010 SHALL have port out_valid, output, 1, out_data/out_keep valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts word.
REQ-012 SHALL have port out_data, output, 32, four packed int8 results, lane 0 = bits 7:0 = oldest.
REQ-013 SHALL have port out_keep, output, 4, per-lane valid mask.

Function
REQ-014 SHALL accept input on in_valid & in_ready; transfer on out_valid & out_ready.
REQ-015 SHALL compute stage 1 (registered): sum29 = sign-extended in_data + sign-extended bias.
REQ-016 SHALL compute stage 2 (registered): for shift>0, r = (sum29 + 2^(shift-1)) >>> shift (arithmetic); for shift 0, r = sum29; if relu_en and r<0 then r=0; saturate to [-128,127].
REQ-017 SHALL write the stage-2 byte into packer lane lane_idx (2-bit counter), incrementing lane_idx; when lane 3 is written, push {lanes, keep=4'hF} to a 4-entry output FIFO and reset lane_idx to 0 with all lanes zeroed.
REQ-018 SHALL give latency of 3 cycles: fourth byte accepted at cycle t -> out_valid at t+3 if FIFO was empty.
REQ-019 SHALL drive in_ready = (fifo_count <= 2), registered-count based; pipeline never stalls and FIFO never overflows.
REQ-020 SHALL run FSM IDLE/RUN/DRAIN: IDLE->RUN on first accept; RUN->DRAIN on flush (or pending flush); DRAIN waits until stages 1-2 empty and fifo_count<=3, then pushes partial word if lane_idx>0 (keep = lanes written, unwritten bytes 0x00), clears lane_idx, -> IDLE.
REQ-021 SHALL, when flush coincides with an accepted input, include that input in the flushed word.
REQ-022 SHALL hold in_ready low in DRAIN; flush in IDLE with lane_idx 0 produces no word.
REQ-023 SHALL hold out_data/out_keep stable while out_valid & !out_ready.
REQ-024 SHALL handle simultaneous FIFO push and pop with count unchanged; pointers wrap mod 4.

Reset
REQ-025 SHALL, on CLR_N low, set immediately: out_valid 0, out_data 0, out_keep 0, in_ready 0, FIFO empty, lane_idx 0, stage valids 0, FSM IDLE; in_ready rises the first cycle after release.
REQ-026 SHALL discard all in-flight data on reset mid-operation; no partial word emitted after release.

Structure
REQ-027 SHALL place shared constants in package conv3_pkg: ACC_W=28, BIAS_W=16, Q_W=8, LANES=4, FIFO_DEPTH=4, FSM state encoding.
REQ-028 SHALL implement the output FIFO as sub-module conv3_word_fifo (parameterised width/depth); quantize logic stays inline.

Verification
REQ-029 SHALL cover saturation: in_data=1000, bias=24, shift=3 -> (1024+4)>>>3=128 -> lane byte 0x7F.
REQ-030 SHALL cover negatives: in_data=-5000, bias=0, shift=4, relu_en=0 -> -312 -> 0x80; same with relu_en=1 -> 0x00.
REQ-031 SHALL cover packing: bytes 1,2,3,4 (shift 0, bias 0) back-to-back -> one word 0x04030201, keep 0xF, out_valid 3 cycles after 4th accept.
REQ-032 SHALL cover flush: inputs 5,6 then flush -> word 0x00000605, keep 0x3, FSM back to IDLE, next word starts lane 0.
REQ-033 SHALL cover backpressure: out_ready=0, 16 inputs offered -> in_ready drops at fifo_count 3, no loss/duplication; release -> words in order.
REQ-034 SHALL cover reset: CLR_N low after 2 inputs accepted -> out_valid 0 immediately, no word emitted after release.
